// File: rtl/ads_sample_sequencer.sv
// ads_sample_sequencer: periodic conversion scheduler for the ADS8363 path.
// A programmable tick starts a two-slot SPI command frame. Each slot issues one
// command to the 20-bit SPI driver, waits for the driver to go busy and back to
// idle, and latches the low 16 bits of both receive words. Both slots are then
// published together. Dropped ticks and stuck-driver timeouts are reported.
module ads_sample_sequencer #(
    parameter int unsigned CMD_W   = 20,
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic [15:0]       period,
    input  logic [CMD_W-1:0]  cmd_slot0,
    input  logic [CMD_W-1:0]  cmd_slot1,
    input  logic              err_clr,
    input  logic              spi_idle,
    input  logic [DATA_W-1:0] r_data_a,
    input  logic [DATA_W-1:0] r_data_b,
    output logic              spi_start,
    output logic [CMD_W-1:0]  spi_cmd,
    output logic [15:0]       data_a0,
    output logic [15:0]       data_a1,
    output logic [15:0]       data_b0,
    output logic [15:0]       data_b1,
    output logic              frame_valid,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StIssue    = 3'd1;
    localparam logic [2:0] StWaitAck  = 3'd2;
    localparam logic [2:0] StWaitDone = 3'd3;
    localparam logic [2:0] StLatch    = 3'd4;
    localparam logic [2:0] StPublish  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             slot_q, slot_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [15:0]      cnt_q, cnt_d, cnt_cur;
    logic             load_q, load_d;
    logic             tick;
    logic [15:0]      sh_a0_q, sh_a0_d, sh_b0_q, sh_b0_d;
    logic [15:0]      a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic [7:0]       ovr_q, ovr_d;
    logic             err_q, err_d;
    logic             err_set;

    // Driver status nibble in the receive words carries no sample data.
    logic unused_status;
    assign unused_status = ^{r_data_a[DATA_W-1:16], r_data_b[DATA_W-1:16]};

    // Tick down-counter; load_q means "sitting at period", so a held or freshly
    // reloaded counter always reflects the live period input.
    always_comb begin
        cnt_cur = load_q ? period : cnt_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        tick    = 1'b0;
        if (!enable) begin
            load_d = 1'b1;
        end else if (cnt_cur == 16'd0) begin
            tick   = 1'b1;
            load_d = 1'b1;
        end else begin
            cnt_d  = cnt_cur - 16'd1;
            load_d = 1'b0;
        end
    end

    // Frame sequencer: issue, handshake, latch per slot, then publish.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        tmo_d   = tmo_q;
        cmd_d   = cmd_q;
        sh_a0_d = sh_a0_q;
        sh_b0_d = sh_b0_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        err_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    slot_d  = 1'b0;
                    cmd_d   = cmd_slot0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck, StWaitDone: begin
                tmo_d = tmo_q + 1'b1;
                if ((state_q == StWaitAck) && !spi_idle) begin
                    state_d = StWaitDone;
                end else if ((state_q == StWaitDone) && spi_idle) begin
                    state_d = StLatch;
                end else if (tmo_q == TmoLast) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
            StLatch: begin
                if (!slot_q) begin
                    sh_a0_d = r_data_a[15:0];
                    sh_b0_d = r_data_b[15:0];
                    slot_d  = 1'b1;
                    cmd_d   = cmd_slot1;
                    state_d = StIssue;
                end else begin
                    // Publish registers load on entry to PUBLISH so the data
                    // change lands in the same cycle as frame_valid.
                    a0_d    = sh_a0_q;
                    b0_d    = sh_b0_q;
                    a1_d    = r_data_a[15:0];
                    b1_d    = r_data_b[15:0];
                    state_d = StPublish;
                end
            end
            StPublish: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Overrun counter (saturating) and sticky timeout flag; set beats clear.
    always_comb begin
        ovr_d = ovr_q;
        if (tick && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            slot_q  <= 1'b0;
            tmo_q   <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b1;
            sh_a0_q <= '0;
            sh_b0_q <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            ovr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            sh_a0_q <= sh_a0_d;
            sh_b0_q <= sh_b0_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
        end
    end

    assign spi_start   = (state_q == StIssue);
    assign spi_cmd     = cmd_q;
    assign busy        = (state_q != StIdle);
    assign frame_valid = (state_q == StPublish);
    assign data_a0     = a0_q;
    assign data_a1     = a1_q;
    assign data_b0     = b0_q;
    assign data_b1     = b1_q;
    assign overrun_cnt = ovr_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_ads_sample_sequencer.sv
// Bench for ads_sample_sequencer: a frame-timeline model predicts every output
// each cycle; directed scenarios add hand-computed literal checks.
module tb_ads_sample_sequencer;

    localparam int TIMEOUT = 255;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] period    = 16'd99;
    logic [19:0] cmd_slot0 = 20'h0A000;
    logic [19:0] cmd_slot1 = 20'h0B000;
    logic        err_clr   = 1'b0;
    logic        spi_idle  = 1'b1;
    logic [19:0] r_data_a  = '0;
    logic [19:0] r_data_b  = '0;
    logic        spi_start;
    logic [19:0] spi_cmd;
    logic [15:0] data_a0, data_a1, data_b0, data_b1;
    logic        frame_valid, busy, timeout_err;
    logic [7:0]  overrun_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ads_sample_sequencer #(
        .CMD_W  (20),
        .DATA_W (20),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .enable     (enable),
        .period     (period),
        .cmd_slot0  (cmd_slot0),
        .cmd_slot1  (cmd_slot1),
        .err_clr    (err_clr),
        .spi_idle   (spi_idle),
        .r_data_a   (r_data_a),
        .r_data_b   (r_data_b),
        .spi_start  (spi_start),
        .spi_cmd    (spi_cmd),
        .data_a0    (data_a0),
        .data_a1    (data_a1),
        .data_b0    (data_b0),
        .data_b1    (data_b1),
        .frame_valid(frame_valid),
        .busy       (busy),
        .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver model (inputs for the current cycle, at +3) ----------
    int drv_busy = 30;  // busy window length; 0 = driver never leaves idle
    int ls       = -1000;
    int txn      = 0;

    always @(posedge sys_clk) begin
        logic [15:0] va, vb;
        #3;
        if (!sys_rst_n) begin
            ls       = -1000;
            spi_idle = 1'b1;
        end else begin
            if (spi_start && drv_busy > 0) ls = cyc;
            spi_idle = !(drv_busy > 0 && cyc >= ls + 1 && cyc <= ls + drv_busy);
            if (drv_busy > 0 && cyc == ls + drv_busy + 1) begin
                va       = 16'h1111 * 16'(txn + 1);
                vb       = 16'hA0A0 + 16'(txn);
                r_data_a = {4'hC, va};
                r_data_b = {4'h3, vb};
                txn++;
            end
        end
    end

    // ---------------- reference model (frame timeline, at +4) ----------------------
    int          m_cnt, m_ovr, m_t, m_s0, m_s1, m_l0, m_l1, m_pub, m_abort, m_free;
    logic        m_err;
    logic [19:0] m_cmd;
    logic [15:0] m_a0, m_a1, m_b0, m_b1, sh_a0, sh_b0, sh_a1, sh_b1;

    task automatic model_reset();
        m_cnt = int'(period);
        m_ovr = 0; m_t = -1; m_s0 = -1; m_s1 = -1; m_l0 = -1; m_l1 = -1;
        m_pub = -1; m_abort = -1; m_free = 0; m_err = 1'b0; m_cmd = '0;
        m_a0 = '0; m_a1 = '0; m_b0 = '0; m_b1 = '0;
        sh_a0 = '0; sh_b0 = '0; sh_a1 = '0; sh_b1 = '0;
    endtask

    task automatic model_step();
        bit tk;
        int c;
        c  = cyc;
        tk = 0;
        if (!enable) m_cnt = int'(period);
        else if (m_cnt == 0) begin tk = 1; m_cnt = int'(period); end
        else m_cnt--;
        if (tk) begin
            if (c >= m_free) begin
                m_t  = c;
                m_s0 = c + 1;
                if (drv_busy > 0) begin
                    m_l0 = c + drv_busy + 3;
                    m_s1 = c + drv_busy + 4;
                    m_l1 = c + 2 * drv_busy + 6;
                    m_pub = c + 2 * drv_busy + 7;
                    m_abort = -1;
                    m_free = m_pub + 1;
                end else begin
                    m_l0 = -1; m_s1 = -1; m_l1 = -1; m_pub = -1;
                    m_abort = c + TIMEOUT + 2;
                    m_free  = m_abort;
                end
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
        end
        if (c == m_l0) begin sh_a0 = r_data_a[15:0]; sh_b0 = r_data_b[15:0]; end
        if (c == m_l1) begin sh_a1 = r_data_a[15:0]; sh_b1 = r_data_b[15:0]; end
        if (c + 1 == m_s0) m_cmd = cmd_slot0;
        if (c + 1 == m_s1) m_cmd = cmd_slot1;
        if (c + 1 == m_pub) begin m_a0 = sh_a0; m_a1 = sh_a1; m_b0 = sh_b0; m_b1 = sh_b1; end
        if (c + 1 == m_abort) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    initial model_reset();

    always @(posedge sys_clk) begin
        #4;
        if (!sys_rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare (at +1) -----------------------------------
    always @(posedge sys_clk) begin
        logic e_start, e_busy, e_fv;
        cyc++;
        #1;
        e_start = (cyc == m_s0) || (cyc == m_s1);
        e_busy  = (cyc > m_t) && (cyc < m_free);
        e_fv    = (cyc == m_pub);
        check("ctrl", 64'({spi_start, busy, frame_valid, spi_cmd}),
              64'({e_start, e_busy, e_fv, m_cmd}));
        check("data", {data_a0, data_a1, data_b0, data_b1}, {m_a0, m_a1, m_b0, m_b1});
        check("status", 64'({overrun_cnt, timeout_err}), 64'({8'(m_ovr), m_err}));
    end

    // ---------------- directed stimulus (at +2) -----------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return spi_start;
            1:       return frame_valid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (sig(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({name, "_wait"}, 64'(sig(which)), 64'd1);
    endtask

    initial begin
        int e, s0, s1, f0, f1, i0, i2, r, nfv, nst;
        step(2);
        check("reset_outputs", 64'({spi_start, busy, frame_valid, spi_cmd, overrun_cnt,
              timeout_err}), 64'd0);
        check("reset_data", {data_a0, data_a1, data_b0, data_b1}, 64'd0);
        step(1);
        sys_rst_n = 1'b1;
        step(3);

        // Basic frame: period 99, 30-cycle driver busy window.
        enable = 1'b1;
        e = cyc;
        wait_for("basic_s0", 0, 200, s0);
        check("basic_tick_to_start", 64'(s0 - e), 64'd100);
        check("basic_cmd0", 64'(spi_cmd), 64'h0A000);
        wait_for("basic_s1", 0, 100, s1);
        check("basic_slot_gap", 64'(s1 - s0), 64'd33);
        check("basic_cmd1", 64'(spi_cmd), 64'h0B000);
        wait_for("basic_fv", 1, 100, f0);
        check("basic_start_to_publish", 64'(f0 - s0), 64'd66);
        check("basic_data", {data_a0, data_a1, data_b0, data_b1},
              {16'h1111, 16'h2222, 16'hA0A0, 16'hA0A1});
        wait_for("basic_fv2", 1, 150, f1);
        check("basic_frame_spacing", 64'(f1 - f0), 64'd100);
        enable = 1'b0;
        step(1);

        // Timeout: driver never goes busy.
        drv_busy = 0;
        step(1);
        enable = 1'b1;
        wait_for("tmo_s0", 0, 200, i0);
        step((i0 + 255) - cyc);
        check("tmo_not_yet", 64'(timeout_err), 64'd0);
        step(1);
        check("tmo_set", 64'(timeout_err), 64'd1);
        check("tmo_no_busy", 64'(busy), 64'd0);
        check("tmo_data_held", {data_a0, data_a1, data_b0, data_b1},
              {16'h3333, 16'h4444, 16'hA0A2, 16'hA0A3});
        wait_for("tmo_restart", 0, 100, i2);
        check("tmo_restart_gap", 64'(i2 - i0), 64'd300);
        check("tmo_overrun", 64'(overrun_cnt), 64'd2);
        step(1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr", 64'(timeout_err), 64'd0);

        // Timeout and err_clr in the same cycle: set wins.
        step((i2 + 255) - cyc);
        err_clr = 1'b1;
        check("simul_pre", 64'(timeout_err), 64'd0);
        step(1);
        err_clr = 1'b0;
        enable  = 1'b0;
        check("simul_set_wins", 64'(timeout_err), 64'd1);
        step(1);
        drv_busy = 30;
        step(1);

        // Enable dropped during slot-0 WAIT_DONE: frame still completes.
        enable = 1'b1;
        wait_for("drop_s0", 0, 200, s0);
        step(5);
        enable = 1'b0;
        nfv = 0;
        nst = 0;
        for (int k = 0; k < 150; k++) begin
            step(1);
            if (frame_valid) nfv++;
            if (spi_start) nst++;
        end
        check("drop_frame_valid", 64'(nfv), 64'd1);
        check("drop_starts", 64'(nst), 64'd1);

        // Reset during slot-1 WAIT_DONE.
        enable = 1'b1;
        wait_for("rst_s0", 0, 200, s0);
        wait_for("rst_s1", 0, 100, s1);
        step(5);
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", 64'({spi_start, busy, frame_valid, spi_cmd, overrun_cnt,
              timeout_err}), 64'd0);
        check("rst_async_data", {data_a0, data_a1, data_b0, data_b1}, 64'd0);
        step(3);
        sys_rst_n = 1'b1;
        r = cyc;
        wait_for("rst_first_start", 0, 300, s0);
        // Release cycle holds the counter at period; tick after period decrements.
        check("rst_release_to_start", 64'(s0 - r), 64'd100);
        enable = 1'b0;
        wait_for("rst_idle", 2, 200, f0);

        // Overrun: period 19 against a 68-cycle frame.
        period = 16'd19;
        step(2);
        enable = 1'b1;
        wait_for("ovr_s0", 0, 100, s0);
        wait_for("ovr_fv", 1, 100, f0);
        wait_for("ovr_next", 0, 100, s1);
        check("ovr_restart_gap", 64'(s1 - s0), 64'd80);
        check("ovr_first_frame", 64'(overrun_cnt), 64'd3);
        for (int k = 0; k < 8000 && overrun_cnt != 8'hFF; k++) step(1);
        check("ovr_saturated", 64'(overrun_cnt), 64'hFF);
        step(200);
        check("ovr_hold", 64'(overrun_cnt), 64'hFF);
        enable = 1'b0;
        step(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
